// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder
// -------------------
// Receives the rotating one-hot column strobe from the scan-clock generator,
// samples the keypad rows once per column, assembles full scan frames,
// debounces a single key across several frames and hands press/release
// events to the CPU-side I/O register.
//
// Ports
//   clk_in      system clock
//   rst_n       asynchronous active-low reset
//   col_strobe  one-hot column strobe (COLS bits)
//   row_in      keypad rows, active-low, asynchronous (ROWS bits)
//   ev_valid    event pending
//   ev_code     key code = col*ROWS + row
//   ev_release  0 = press, 1 = release
//   ev_ready    consumer accepts the event
//   ev_overrun  one-cycle pulse when an event is dropped
//   scan_err    one-cycle pulse on a malformed strobe
//   dbg_state   debounce FSM state (IDLE=0, PRESS_CAND=1, HELD=2, REL_CAND=3)
//   dbg_cnt     debounce frame counter
//
// Event handshake: ev_valid/ev_code/ev_release are held stable while
// ev_valid=1 and ev_ready=0; a transfer happens in any cycle where
// ev_valid && ev_ready, and a new event may be loaded in that same cycle.
module keypad_scan_decoder #(
   parameter int COLS     = 5,
   parameter int ROWS     = 4,
   parameter int CODE_W   = 5,
   parameter int SETTLE   = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic                              clk_in,
   input  logic                              rst_n,
   input  logic [COLS-1:0]                   col_strobe,
   input  logic [ROWS-1:0]                   row_in,
   output logic                              ev_valid,
   output logic [CODE_W-1:0]                 ev_code,
   output logic                              ev_release,
   input  logic                              ev_ready,
   output logic                              ev_overrun,
   output logic                              scan_err,
   output logic [1:0]                        dbg_state,
   output logic [$clog2(DEBOUNCE+1)-1:0]     dbg_cnt
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SET_W = $clog2(SETTLE + 2);
   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI, FR_INVALID} frame_t;
   typedef enum logic [1:0] {IDLE, PRESS_CAND, HELD, REL_CAND} db_state_t;

   // ---------------------------------------------------------------
   // Row synchroniser; reset to "not pressed"
   // ---------------------------------------------------------------
   logic [ROWS-1:0] row_meta, row_sync, row_hit;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= '1;
         row_sync <= '1;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

   assign row_hit = ~row_sync;

   // ---------------------------------------------------------------
   // Strobe tracking and settle counter
   // ---------------------------------------------------------------
   logic [COLS-1:0]  strobe_q, strobe_prev;
   logic [SET_W-1:0] settle_cnt;
   logic             strobe_change, sample;

   assign strobe_change = (strobe_q != strobe_prev);
   // The counter parks at SETTLE+1 after the sample so each column is
   // sampled exactly once; a strobe change in the sample cycle wins.
   assign sample = (settle_cnt == SET_W'(SETTLE)) && !strobe_change;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         strobe_q    <= '0;
         strobe_prev <= '0;
         settle_cnt  <= '0;
      end else begin
         strobe_q    <= col_strobe;
         strobe_prev <= strobe_q;
         if (strobe_change)
            settle_cnt <= SET_W'(1);
         else if (settle_cnt != '0 && settle_cnt <= SET_W'(SETTLE))
            settle_cnt <= settle_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Strobe / row decode for the current column
   // ---------------------------------------------------------------
   logic [1:0]        strobe_bits;   // set bits, saturating at 2
   logic [COL_W-1:0]  strobe_idx;
   logic [1:0]        col_keys;      // pressed rows, saturating at 2
   logic [ROW_W-1:0]  col_first_row;

   always_comb begin
      strobe_bits   = 2'd0;
      strobe_idx    = '0;
      col_keys      = 2'd0;
      col_first_row = '0;
      for (int i = 0; i < COLS; i++) begin
         if (strobe_q[i]) begin
            if (strobe_bits != 2'd2)
               strobe_bits = strobe_bits + 2'd1;
            strobe_idx = COL_W'(i);
         end
      end
      // Descending scan leaves the lowest pressed row in col_first_row.
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (row_hit[r]) begin
            if (col_keys != 2'd2)
               col_keys = col_keys + 2'd1;
            col_first_row = ROW_W'(r);
         end
      end
   end

   // ---------------------------------------------------------------
   // Frame accumulation
   // ---------------------------------------------------------------
   logic              synced;        // seen a column-0 sample since reset
   logic [COL_W-1:0]  exp_col;
   logic              frame_ok;
   logic [1:0]        acc_keys;
   logic [CODE_W-1:0] acc_code;
   logic              frame_done;
   frame_t            frame_kind;
   logic [CODE_W-1:0] frame_code;

   logic              take, col_ok, is_first, is_last, base_ok;
   logic [COL_W-1:0]  next_col;
   logic [CODE_W-1:0] col_code, first_code;
   logic [1:0]        base_keys, sum_keys;
   logic [2:0]        raw_keys;
   frame_t            kind_now;

   assign is_first = (strobe_idx == '0);
   assign is_last  = (strobe_idx == COL_W'(COLS - 1));
   assign col_ok   = (strobe_bits == 2'd1) && (strobe_idx == exp_col);
   // Until the first column-0 sample after reset every sample is ignored.
   assign take     = sample && (synced || ((strobe_bits == 2'd1) && is_first));
   assign next_col = is_last ? '0 : strobe_idx + 1'b1;
   assign col_code = CODE_W'(strobe_idx) * CODE_W'(ROWS) + CODE_W'(col_first_row);

   // Column 0 starts a fresh frame, so it ignores the old accumulators.
   assign base_keys  = is_first ? 2'd0 : acc_keys;
   assign base_ok    = is_first ? 1'b1 : frame_ok;
   assign raw_keys   = {1'b0, base_keys} + {1'b0, col_keys};
   assign sum_keys   = (raw_keys >= 3'd2) ? 2'd2 : raw_keys[1:0];
   assign first_code = (base_keys == 2'd0) ? col_code : acc_code;

   always_comb begin
      kind_now = FR_MULTI;
      if (!base_ok)
         kind_now = FR_INVALID;
      else if (sum_keys == 2'd0)
         kind_now = FR_NONE;
      else if (sum_keys == 2'd1)
         kind_now = FR_SINGLE;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         synced     <= 1'b0;
         exp_col    <= '0;
         frame_ok   <= 1'b0;
         acc_keys   <= 2'd0;
         acc_code   <= '0;
         frame_done <= 1'b0;
         frame_kind <= FR_NONE;
         frame_code <= '0;
         scan_err   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         scan_err   <= 1'b0;
         if (take) begin
            synced <= 1'b1;
            if (col_ok) begin
               exp_col  <= next_col;
               frame_ok <= base_ok;
               acc_keys <= sum_keys;
               acc_code <= first_code;
               if (is_last) begin
                  frame_done <= 1'b1;
                  frame_kind <= kind_now;
                  frame_code <= first_code;
               end
            end else begin
               scan_err <= 1'b1;
               frame_ok <= 1'b0;
               exp_col  <= (strobe_bits == 2'd1) ? next_col : '0;
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Debounce FSM
   // ---------------------------------------------------------------
   db_state_t         state_q, state_d;
   logic [CODE_W-1:0] cand_q, cand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              emit, emit_rel, hit, same, usable;

   assign usable  = frame_done && (frame_kind == FR_NONE || frame_kind == FR_SINGLE);
   assign hit     = (frame_kind == FR_SINGLE);
   assign same    = hit && (frame_code == cand_q);
   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cand_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      emit     = 1'b0;
      emit_rel = 1'b0;
      if (usable) begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  cand_d  = frame_code;
                  cnt_d   = CNT_W'(1);
                  state_d = PRESS_CAND;
               end
            end
            PRESS_CAND: begin
               if (!hit) begin
                  state_d = IDLE;
               end else if (same) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                     emit    = 1'b1;
                     state_d = HELD;
                  end
               end else begin
                  cand_d = frame_code;
                  cnt_d  = CNT_W'(1);
               end
            end
            HELD: begin
               // Any single key keeps the hold; rollover is not tracked.
               if (!hit) begin
                  cnt_d   = CNT_W'(1);
                  state_d = REL_CAND;
               end
            end
            REL_CAND: begin
               if (!hit) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                     emit     = 1'b1;
                     emit_rel = 1'b1;
                     state_d  = IDLE;
                  end
               end else if (same) begin
                  state_d = HELD;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign dbg_state = state_q;
   assign dbg_cnt   = cnt_q;

   // ---------------------------------------------------------------
   // Event register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         ev_valid   <= 1'b0;
         ev_code    <= '0;
         ev_release <= 1'b0;
         ev_overrun <= 1'b0;
      end else begin
         ev_overrun <= 1'b0;
         if (emit) begin
            if (!ev_valid || ev_ready) begin
               ev_valid   <= 1'b1;
               ev_code    <= cand_q;
               ev_release <= emit_rel;
            end else begin
               // Held event stays; the new one is lost.
               ev_overrun <= 1'b1;
            end
         end else if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: rotating strobe with a key-matrix row model,
// expected events queued as stimulus is driven and checked on acceptance.
module tb_keypad_scan_decoder;

   localparam int COLS     = 5;
   localparam int ROWS     = 4;
   localparam int CODE_W   = 5;
   localparam int SETTLE   = 4;
   localparam int DEBOUNCE = 3;
   localparam int DWELL    = 20;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRESS = 2'd1;
   localparam logic [1:0] S_HELD  = 2'd2;

   localparam logic [COLS*ROWS-1:0] KEY0  = 20'd1 << 0;
   localparam logic [COLS*ROWS-1:0] KEY9  = 20'd1 << 9;
   localparam logic [COLS*ROWS-1:0] KEY14 = 20'd1 << 14;

   // ---------------- clock / reset ----------------
   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic [COLS-1:0]   col_strobe = '0;
   logic [ROWS-1:0]   row_in;
   logic              ev_valid, ev_release, ev_overrun, scan_err;
   logic [CODE_W-1:0] ev_code;
   logic              ev_ready = 1'b1;
   logic [1:0]        dbg_state;
   logic [1:0]        dbg_cnt;
   logic [COLS*ROWS-1:0] key_mask = '0;

   keypad_scan_decoder #(
      .COLS(COLS), .ROWS(ROWS), .CODE_W(CODE_W), .SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .col_strobe(col_strobe), .row_in(row_in),
      .ev_valid(ev_valid), .ev_code(ev_code), .ev_release(ev_release),
      .ev_ready(ev_ready), .ev_overrun(ev_overrun), .scan_err(scan_err),
      .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
   );

   // Key matrix: a row reads low when a pressed key sits in a strobed column.
   always_comb begin
      row_in = '1;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            if (col_strobe[c] && key_mask[c*ROWS + r])
               row_in[r] = 1'b0;
   end

   // ---------------- scoreboard ----------------
   logic [CODE_W:0] exp_q[$];   // {release, code}
   int vectors     = 0;
   int miscompares = 0;
   int err_cnt     = 0;
   int overrun_cnt = 0;
   int rise_cyc    = -1;
   int col4_cyc    = 0;
   logic ev_valid_d = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (rst_n) begin
         if (ev_valid && !ev_valid_d) rise_cyc = cyc;
         if (ev_overrun) overrun_cnt++;
         if (scan_err) err_cnt++;
         if (ev_valid && ev_ready) begin
            check("event_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
               check("event_value", 32'({ev_release, ev_code}), 32'(exp_q.pop_front()));
         end
      end
      ev_valid_d = ev_valid && rst_n;
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #2;
      end
   endtask

   task automatic drive_col(input logic [COLS-1:0] s);
      col_strobe = s;
      tick(DWELL);
   endtask

   task automatic run_frame();
      logic [COLS-1:0] s;
      for (int c = 0; c < COLS; c++) begin
         s = COLS'(1) << c;
         if (c == COLS - 1) col4_cyc = cyc;
         drive_col(s);
      end
   endtask

   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) run_frame();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ev_valid"}, 32'(ev_valid), 32'd0);
      check({tag, "_ev_code"}, 32'(ev_code), 32'd0);
      check({tag, "_ev_release"}, 32'(ev_release), 32'd0);
      check({tag, "_ev_overrun"}, 32'(ev_overrun), 32'd0);
      check({tag, "_scan_err"}, 32'(scan_err), 32'd0);
      check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
   endtask

   // ---------------- directed sequence ----------------
   int base;

   initial begin
      // Reset
      tick(3);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      tick(1);
      check_outputs_zero("post_reset");

      // 1. Press col 2 / row 1 -> code 9
      key_mask = KEY9;
      exp_q.push_back({1'b0, 5'd9});
      run_frames(2);
      check("press_not_yet", 32'(exp_q.size()), 32'd1);
      run_frame();
      check("press_done", 32'(exp_q.size()), 32'd0);
      // registered at col4_cyc+1, sampled SETTLE cycles later, valid 2 after
      check("press_timing", 32'(rise_cyc), 32'(col4_cyc + 1 + SETTLE + 2));
      run_frames(2);
      check("press_held_state", 32'(dbg_state), 32'(S_HELD));

      // 2. Release
      key_mask = '0;
      exp_q.push_back({1'b1, 5'd9});
      run_frames(2);
      check("release_not_yet", 32'(exp_q.size()), 32'd1);
      run_frame();
      check("release_done", 32'(exp_q.size()), 32'd0);
      check("release_idle", 32'(dbg_state), 32'(S_IDLE));

      // 3. Bounce
      key_mask = KEY9;
      run_frames(2);
      check("bounce_cand_state", 32'(dbg_state), 32'(S_PRESS));
      check("bounce_cand_cnt", 32'(dbg_cnt), 32'd2);
      key_mask = '0;
      run_frame();
      check("bounce_gap_idle", 32'(dbg_state), 32'(S_IDLE));
      key_mask = KEY9;
      run_frames(2);
      key_mask = '0;
      run_frame();
      check("bounce_end_idle", 32'(dbg_state), 32'(S_IDLE));

      // 4. Ghosting, then single key 14
      key_mask = KEY0 | KEY14;
      run_frames(4);
      check("ghost_idle", 32'(dbg_state), 32'(S_IDLE));
      key_mask = KEY14;
      exp_q.push_back({1'b0, 5'd14});
      run_frames(2);
      check("ghost_press_not_yet", 32'(exp_q.size()), 32'd1);
      run_frame();
      check("ghost_press_done", 32'(exp_q.size()), 32'd0);
      key_mask = '0;
      exp_q.push_back({1'b1, 5'd14});
      run_frames(3);
      check("ghost_release_done", 32'(exp_q.size()), 32'd0);

      // 5. Malformed strobes between good frames of key 9
      key_mask = KEY9;
      base = err_cnt;
      run_frame();
      check("mal_start_cnt", 32'(dbg_cnt), 32'd1);
      for (int c = 0; c < COLS - 1; c++) drive_col(COLS'(1) << c);
      drive_col(5'b00110);
      for (int c = 0; c < COLS - 1; c++) drive_col(COLS'(1) << c);
      drive_col(5'b00000);
      drive_col(5'b00001);
      drive_col(5'b00100);
      drive_col(5'b01000);
      drive_col(5'b10000);
      check("mal_err_pulses", 32'(err_cnt - base), 32'd3);
      check("mal_state", 32'(dbg_state), 32'(S_PRESS));
      check("mal_cnt_kept", 32'(dbg_cnt), 32'd1);
      exp_q.push_back({1'b0, 5'd9});
      run_frame();
      check("mal_press_not_yet", 32'(exp_q.size()), 32'd1);
      run_frame();
      check("mal_press_done", 32'(exp_q.size()), 32'd0);
      key_mask = '0;
      exp_q.push_back({1'b1, 5'd9});
      run_frames(3);
      check("mal_release_done", 32'(exp_q.size()), 32'd0);

      // 6a. Backpressure: press held, release dropped
      ev_ready = 1'b0;
      base = overrun_cnt;
      key_mask = KEY9;
      exp_q.push_back({1'b0, 5'd9});
      run_frames(3);
      key_mask = '0;
      run_frames(3);
      check("bp_overrun", 32'(overrun_cnt - base), 32'd1);
      check("bp_valid", 32'(ev_valid), 32'd1);
      check("bp_code", 32'(ev_code), 32'd9);
      check("bp_release", 32'(ev_release), 32'd0);
      ev_ready = 1'b1;
      tick(3);
      check("bp_drained", 32'(exp_q.size()), 32'd0);
      check("bp_valid_clear", 32'(ev_valid), 32'd0);

      // 6b. Reset mid-frame at column 2
      key_mask = KEY9;
      drive_col(5'b00001);
      drive_col(5'b00010);
      col_strobe = 5'b00100;
      tick(8);
      rst_n = 1'b0;
      tick(1);
      check_outputs_zero("mid_reset");
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check_outputs_zero("mid_post_reset");
      base = err_cnt;
      tick(DWELL - 12);
      drive_col(5'b01000);
      drive_col(5'b10000);
      check("rst_partial_no_err", 32'(err_cnt - base), 32'd0);
      exp_q.push_back({1'b0, 5'd9});
      run_frames(2);
      check("rst_press_not_yet", 32'(exp_q.size()), 32'd1);
      run_frame();
      check("rst_press_done", 32'(exp_q.size()), 32'd0);

      tick(5);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_scan_decoder.md
# keypad_scan_decoder

Receive side of the rotating one-hot scan strobe produced by the board's scan-clock generator. It samples the keypad row lines once per strobed column, assembles a full scan frame, debounces the key over several frames, and presents press and release events to the CPU-side I/O register through a valid/ready handshake. It sits between the scan-clock generator (strobe source), the keypad pins (row inputs) and the MIPS I/O bus.

## Interface

- COLS, 5: number of columns, equal to the strobe width.
- ROWS, 4: number of row inputs.
- CODE_W, 5: key-code width; COLS*ROWS <= 2**CODE_W.
- SETTLE, 4: cycles from strobe change to row sample; must be less than the strobe dwell.
- DEBOUNCE, 3: consecutive identical frames needed to accept a press or release; minimum 2.

- clk_in  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- col_strobe  input  COLS  one-hot column strobe from the scan-clock generator.
- row_in  input  ROWS  keypad rows, active-low (0 = pressed), asynchronous.
- ev_valid  output  1  event pending; reset 0.
- ev_code  output  CODE_W  key code = col*ROWS + row; reset 0.
- ev_release  output  1  0 = press, 1 = release; reset 0.
- ev_ready  input  1  consumer accepts the event.
- ev_overrun  output  1  one-cycle pulse when an event is dropped; reset 0.
- scan_err  output  1  one-cycle pulse on a malformed strobe; reset 0.

## Operation

- **Row synchronisation.** row_in passes through a 2-flop synchroniser and is inverted internally, so 1 = pressed.
- **Strobe tracking.** col_strobe is registered each cycle. A change is any cycle where the registered value differs from the previous one. A change restarts the settle counter.
- **Column sampling.** The synchronised rows are sampled exactly once per column, when the settle counter reaches SETTLE. The column index is the position of the strobe bit.
- **Strobe validity.**
  - Checked at the sample cycle.
  - Malformed if the strobe is not one-hot (zero bits or two or more bits set), or if the index differs from the expected column.
  - On a malformed strobe: pulse scan_err, mark the current frame invalid, and set the expected column to (index+1) mod COLS. For an all-zero or multi-bit strobe, set it to 0.
- **Frame accumulation.**
  - Starts at column 0 and completes at the sample of column COLS-1.
  - Tracks the pressed count (saturating at 2) and the code of the first pressed key.
  - Classification: NONE (0 keys), SINGLE(c) (1 key), MULTI (2 or more keys, ghosting), or INVALID.
- **Frames that do not affect the debounce.** MULTI and INVALID frames are ignored: the debounce FSM state and counter are unchanged.
- **Debounce FSM** (states IDLE, PRESS_CAND, HELD, REL_CAND; candidate code cand; counter cnt; reset state IDLE, cnt=0):
  - IDLE:
    - SINGLE(c) -> cand=c, cnt=1, go to PRESS_CAND.
    - NONE -> stay.
  - PRESS_CAND:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE, emit press(cand) and go to HELD.
    - SINGLE(other) -> cand=other, cnt=1.
    - NONE -> IDLE.
  - HELD:
    - SINGLE(cand) or SINGLE(other) -> stay. Rollover is not supported.
    - NONE -> cnt=1, go to REL_CAND.
  - REL_CAND:
    - NONE -> cnt+1. When cnt reaches DEBOUNCE, emit release(cand) and go to IDLE.
    - SINGLE(cand) -> HELD.
    - SINGLE(other) -> stay, cnt unchanged.
- **Event register.**
  - An emitted event loads ev_code/ev_release and sets ev_valid.
  - ev_valid && ev_ready clears ev_valid. If a new event arrives in that same cycle, it is loaded instead and ev_valid stays 1, with no bubble.
  - If an event is emitted while ev_valid=1 and ev_ready=0, the new event is dropped, ev_overrun pulses, and the held event is unchanged. The FSM still advances.
- **Reset mid-operation.** All state clears. The partial frame is discarded and the expected column is 0. Column samples are ignored until the first column-0 sample after reset.

## Timing

- row_in to sampled value: 2 cycles of synchroniser latency.
- Column sample: SETTLE cycles after the registered strobe change.
- Frame classification is registered 1 cycle after the column COLS-1 sample. The FSM update and ev_valid take effect on the next edge, so ev_valid rises 2 cycles after the final sample edge.
- ev_code and ev_release are stable while ev_valid=1 and ev_ready=0.
- scan_err and ev_overrun are single-cycle pulses, asserted in the cycle after the detecting sample or emit.
- Every output is 0 during reset and in the first cycle after reset deassertion.

## Test plan

All scenarios use COLS=5, ROWS=4, SETTLE=4, DEBOUNCE=3, strobe dwell 20 cycles (bench model rotates 00001 -> 00010 -> ... -> 10000).

1. **Press.** Hold col 2 / row 1 low for 5 frames, ev_ready=1 -> exactly one event: ev_code=9, ev_release=0, ev_valid rising 2 cycles after the 3rd frame's col-4 sample.
2. **Release.** Release the key from scenario 1 -> one event after 3 empty frames: ev_code=9, ev_release=1.
3. **Bounce.** Key present 2 frames, absent 1, present 2, then absent -> no event; FSM returns to IDLE.
4. **Ghosting.** Col 0 / row 0 and col 3 / row 2 pressed together for 4 frames -> no event, FSM unchanged. Drop to col 3 / row 2 only -> press code 14 after 3 frames.
5. **Malformed strobe.** Inject strobe 00110, then 00000, then a skipped column (00001 -> 00100) -> one scan_err pulse each; those frames are invalid and the debounce cnt is unchanged.
6. **Backpressure and reset.**
   - Hold ev_ready=0 through a press and its release -> press (code 9) held; release dropped; ev_overrun pulses once.
   - Assert rst_n mid-frame at col 2 -> all outputs 0; the first event needs 3 full frames starting at col 0.
